// File: rtl/rob_commit_pkg.sv
// Shared Tomasulo definitions: ROB geometry, function-code classes and the
// per-entry record kept by the reorder buffer.
package rob_commit_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int ROB_IDX_W  = 3;
    localparam int ROB_DATA_W = 16;
    localparam int ROB_REG_W  = 4;
    localparam int ROB_FUNC_W = 4;

    localparam logic [3:0] FUNC_ADD0 = 4'b0000;
    localparam logic [3:0] FUNC_ADD1 = 4'b0001;
    localparam logic [3:0] FUNC_MUL0 = 4'b0010;
    localparam logic [3:0] FUNC_MUL1 = 4'b0011;

    // Rename-tag value the register bank uses for "value lives in the RF".
    localparam logic [3:0] NO_TAG = 4'b1000;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [ROB_FUNC_W-1:0] func;
        logic [ROB_REG_W-1:0]  rd;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Bundle of the issue, CDB, flush and retire signals around the reorder buffer.
interface rob_commit_if #(
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int FUNC_W = 4
);

    // alloc_valid/alloc_ready is a valid/ready pair: an entry is taken on any
    // clock edge where both are high, alloc_tag names it, and alloc_ready
    // depends only on registered occupancy, never on alloc_valid.
    logic              alloc_valid;
    logic [FUNC_W-1:0] alloc_func;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_tag;

    logic              cdb_valid;
    logic [IDX_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              flush;

    logic              rf_we;
    logic [REG_W-1:0]  rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [IDX_W-1:0]  rf_tag;

    logic              add_free;
    logic              mul_free;
    logic              bch_free;
    logic              tags_clear_all;
    logic [IDX_W:0]    count;

    modport master (
        output alloc_valid, alloc_func, alloc_rd,
        output cdb_valid, cdb_tag, cdb_data,
        output flush,
        input  alloc_ready, alloc_tag,
        input  rf_we, rf_addr, rf_data, rf_tag,
        input  add_free, mul_free, bch_free, tags_clear_all, count
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rd,
        input  cdb_valid, cdb_tag, cdb_data,
        input  flush,
        output alloc_ready, alloc_tag,
        output rf_we, rf_addr, rf_data, rf_tag,
        output add_free, mul_free, bch_free, tags_clear_all, count
    );

endinterface

// File: rtl/rob_commit_unit_class.sv
// Function code to execution-unit class, one-hot {add, mul, bch}; shared with
// the issue stage so both sides agree on which pool a function belongs to.
module rob_unit_class
    import rob_commit_pkg::*;
#(
    parameter int FUNC_W = ROB_FUNC_W
) (
    input  logic [FUNC_W-1:0] func_i,
    output logic              add_o,
    output logic              mul_o,
    output logic              bch_o
);

    always_comb begin
        add_o = 1'b0;
        mul_o = 1'b0;
        bch_o = 1'b0;
        case (func_i)
            FUNC_W'(FUNC_ADD0), FUNC_W'(FUNC_ADD1): add_o = 1'b1;
            FUNC_W'(FUNC_MUL0), FUNC_W'(FUNC_MUL1): mul_o = 1'b1;
            default:                                bch_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: allocates at the tail, collects CDB results, and retires the
// head in program order into the register bank with a pool credit per commit.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int IDX_W  = ROB_IDX_W,
    parameter int DATA_W = ROB_DATA_W,
    parameter int REG_W  = ROB_REG_W,
    parameter int FUNC_W = ROB_FUNC_W
) (
    input  logic       clk1,
    input  logic       rst_n,
    rob_commit_if.slave bus
);

    rob_entry_t        entries_q [DEPTH];
    rob_entry_t        entries_d [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [IDX_W-1:0]  rf_tag_q, rf_tag_d;
    logic              add_free_q, add_free_d;
    logic              mul_free_q, mul_free_d;
    logic              bch_free_q, bch_free_d;
    logic              clear_q, clear_d;

    logic              full;
    logic              alloc_fire;
    logic              commit_fire;
    rob_entry_t        head_e;
    logic              head_add, head_mul, head_bch;
    logic [FUNC_W-1:0] head_func;

    // Occupancy comes from the counter; head==tail is ambiguous between empty and full.
    assign full        = (count_q == (IDX_W+1)'(DEPTH));
    assign head_e      = entries_q[head_q];
    assign head_func   = head_e.func;
    assign alloc_fire  = bus.alloc_valid && !full;
    assign commit_fire = head_e.valid && head_e.ready;

    rob_unit_class #(
        .FUNC_W (FUNC_W)
    ) u_unit_class (
        .func_i (head_func),
        .add_o  (head_add),
        .mul_o  (head_mul),
        .bch_o  (head_bch)
    );

    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        rf_tag_d   = rf_tag_q;
        add_free_d = 1'b0;
        mul_free_d = 1'b0;
        bch_free_d = 1'b0;
        clear_d    = 1'b0;

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            clear_d = 1'b1;
        end else begin
            // Writebacks to an empty slot are stale broadcasts and are dropped.
            if (bus.cdb_valid && entries_q[bus.cdb_tag].valid) begin
                entries_d[bus.cdb_tag].ready = 1'b1;
                entries_d[bus.cdb_tag].data  = bus.cdb_data;
            end

            if (commit_fire) begin
                entries_d[head_q].valid = 1'b0;
                entries_d[head_q].ready = 1'b0;
                head_d     = head_q + IDX_W'(1);
                rf_we_d    = 1'b1;
                rf_addr_d  = head_e.rd;
                rf_data_d  = head_e.data;
                rf_tag_d   = head_q;
                add_free_d = head_add;
                mul_free_d = head_mul;
                bch_free_d = head_bch;
            end

            // Not full means the tail slot is never the head being retired.
            if (alloc_fire) begin
                entries_d[tail_q].valid = 1'b1;
                entries_d[tail_q].ready = 1'b0;
                entries_d[tail_q].func  = bus.alloc_func;
                entries_d[tail_q].rd    = bus.alloc_rd;
                entries_d[tail_q].data  = '0;
                tail_d = tail_q + IDX_W'(1);
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + (IDX_W+1)'(1);
                2'b01:   count_d = count_q - (IDX_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            rf_tag_q   <= '0;
            add_free_q <= 1'b0;
            mul_free_q <= 1'b0;
            bch_free_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            rf_tag_q   <= rf_tag_d;
            add_free_q <= add_free_d;
            mul_free_q <= mul_free_d;
            bch_free_q <= bch_free_d;
            clear_q    <= clear_d;
        end
    end

    assign bus.alloc_ready    = !full;
    assign bus.alloc_tag      = tail_q;
    assign bus.rf_we          = rf_we_q;
    assign bus.rf_addr        = rf_addr_q;
    assign bus.rf_data        = rf_data_q;
    assign bus.rf_tag         = rf_tag_q;
    assign bus.add_free       = add_free_q;
    assign bus.mul_free       = mul_free_q;
    assign bus.bch_free       = bch_free_q;
    assign bus.tags_clear_all = clear_q;
    assign bus.count          = count_q;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed vector table, hand-written corner sequences,
// then random traffic against a program-order queue model of the ROB.
module tb_rob_commit;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;

    rob_commit_if #(.IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W), .FUNC_W(FUNC_W)) bus ();

    rob_commit #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W), .FUNC_W(FUNC_W)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk1 = ~clk1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: in-flight instructions in program order ----------------
    typedef struct {
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        bit                rdy;
        int                tag;
    } m_ent_t;

    m_ent_t            mq[$];
    int                m_tail = 0;
    logic              m_we   = 1'b0;
    logic [REG_W-1:0]  m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    int                m_rtag = 0;
    logic              m_add = 1'b0, m_mul = 1'b0, m_bch = 1'b0, m_clr = 1'b0;

    task automatic model_step(input logic av, input logic [FUNC_W-1:0] fn, input logic [REG_W-1:0] rd,
                              input logic cv, input logic [IDX_W-1:0] ct, input logic [DATA_W-1:0] cd,
                              input logic fl, input logic rs);
        int     pre;
        bit     do_c;
        m_ent_t h;
        m_we  = 1'b0;
        m_add = 1'b0;
        m_mul = 1'b0;
        m_bch = 1'b0;
        m_clr = 1'b0;
        if (!rs) begin
            mq.delete();
            m_tail = 0;
            m_addr = '0;
            m_data = '0;
            m_rtag = 0;
        end else if (fl) begin
            mq.delete();
            m_tail = 0;
            m_clr  = 1'b1;
        end else begin
            pre  = mq.size();
            do_c = (pre > 0) && mq[0].rdy;
            if (do_c) h = mq[0];
            if (cv) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(ct)) begin
                        mq[i].rdy  = 1'b1;
                        mq[i].data = cd;
                    end
                end
            end
            if (do_c) begin
                m_we   = 1'b1;
                m_addr = h.rd;
                m_data = h.data;
                m_rtag = h.tag;
                if (h.func < 4'd2)      m_add = 1'b1;
                else if (h.func < 4'd4) m_mul = 1'b1;
                else                    m_bch = 1'b1;
                mq.delete(0);
            end
            if (av && pre < DEPTH) begin
                mq.push_back('{func: fn, rd: rd, data: '0, rdy: 1'b0, tag: m_tail});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    task automatic compare_model();
        chk("count",          32'(bus.count),          32'(mq.size()));
        chk("alloc_ready",    32'(bus.alloc_ready),    32'(mq.size() < DEPTH));
        chk("alloc_tag",      32'(bus.alloc_tag),      32'(m_tail));
        chk("rf_we",          32'(bus.rf_we),          32'(m_we));
        chk("rf_addr",        32'(bus.rf_addr),        32'(m_addr));
        chk("rf_data",        32'(bus.rf_data),        32'(m_data));
        chk("rf_tag",         32'(bus.rf_tag),         32'(m_rtag));
        chk("add_free",       32'(bus.add_free),       32'(m_add));
        chk("mul_free",       32'(bus.mul_free),       32'(m_mul));
        chk("bch_free",       32'(bus.bch_free),       32'(m_bch));
        chk("tags_clear_all", 32'(bus.tags_clear_all), 32'(m_clr));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic av, input logic [FUNC_W-1:0] fn, input logic [REG_W-1:0] rd,
                         input logic cv, input logic [IDX_W-1:0] ct, input logic [DATA_W-1:0] cd,
                         input logic fl, input logic rs);
        bus.alloc_valid = av;
        bus.alloc_func  = fn;
        bus.alloc_rd    = rd;
        bus.cdb_valid   = cv;
        bus.cdb_tag     = ct;
        bus.cdb_data    = cd;
        bus.flush       = fl;
        rst_n           = rs;
        @(posedge clk1);
        model_step(av, fn, rd, cv, ct, cd, fl, rs);
        #1;
        compare_model();
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic do_alloc(input logic [FUNC_W-1:0] fn, input logic [REG_W-1:0] rd);
        cycle(1'b1, fn, rd, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic do_cdb(input logic [IDX_W-1:0] t, input logic [DATA_W-1:0] d);
        cycle(1'b0, 4'h0, 4'h0, 1'b1, t, d, 1'b0, 1'b1);
    endtask

    task automatic do_flush();
        cycle(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              av;
        logic [FUNC_W-1:0] fn;
        logic [REG_W-1:0]  rd;
        logic              cv;
        logic [IDX_W-1:0]  ct;
        logic [DATA_W-1:0] cd;
        logic              fl;
        int                cnt;
        logic              rdy;
        int                atag;
        logic              we;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        int                rtag;
        logic [2:0]        cred;
        logic              clr;
    } vec_t;

    vec_t vt[13];

    logic [IDX_W-1:0] exp_q[$];
    int               c_tags[$];
    int               t0;

    initial begin
        //          av fn    rd    cv ct    cd        fl  | cnt rdy atag we addr  data      rtag cred    clr
        vt[0]  = '{1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0, 0, 1'b1, 1, 1'b0, 4'h0, 16'h0000, 0, 3'b000, 1'b0};
        vt[0].atag = 0;
        vt[1]  = '{1'b1, 4'h0, 4'h3, 1'b0, 3'd0, 16'h0000, 1'b0, 1, 1'b1, 1, 1'b0, 4'h0, 16'h0000, 0, 3'b000, 1'b0};
        vt[2]  = '{1'b0, 4'h0, 4'h0, 1'b1, 3'd0, 16'h00AB, 1'b0, 1, 1'b1, 1, 1'b0, 4'h0, 16'h0000, 0, 3'b000, 1'b0};
        vt[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0, 0, 1'b1, 1, 1'b1, 4'h3, 16'h00AB, 0, 3'b100, 1'b0};
        vt[4]  = '{1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0, 0, 1'b1, 1, 1'b0, 4'h3, 16'h00AB, 0, 3'b000, 1'b0};
        vt[5]  = '{1'b1, 4'h2, 4'h5, 1'b0, 3'd0, 16'h0000, 1'b0, 1, 1'b1, 2, 1'b0, 4'h3, 16'h00AB, 0, 3'b000, 1'b0};
        vt[6]  = '{1'b1, 4'h7, 4'h9, 1'b1, 3'd1, 16'h1234, 1'b0, 2, 1'b1, 3, 1'b0, 4'h3, 16'h00AB, 0, 3'b000, 1'b0};
        vt[7]  = '{1'b0, 4'h0, 4'h0, 1'b1, 3'd2, 16'h0055, 1'b0, 1, 1'b1, 3, 1'b1, 4'h5, 16'h1234, 1, 3'b010, 1'b0};
        vt[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0, 0, 1'b1, 3, 1'b1, 4'h9, 16'h0055, 2, 3'b001, 1'b0};
        vt[9]  = '{1'b0, 4'h0, 4'h0, 1'b1, 3'd3, 16'hFFFF, 1'b0, 0, 1'b1, 3, 1'b0, 4'h9, 16'h0055, 2, 3'b000, 1'b0};
        vt[10] = '{1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0, 0, 1'b1, 3, 1'b0, 4'h9, 16'h0055, 2, 3'b000, 1'b0};
        vt[11] = '{1'b1, 4'h1, 4'h1, 1'b0, 3'd0, 16'h0000, 1'b1, 0, 1'b1, 0, 1'b0, 4'h9, 16'h0055, 2, 3'b000, 1'b1};
        vt[12] = '{1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0, 0, 1'b1, 0, 1'b0, 4'h9, 16'h0055, 2, 3'b000, 1'b0};

        // reset, then idle
        cycle(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("idle_count",       32'(bus.count),       32'd0);
            chk("idle_alloc_ready", 32'(bus.alloc_ready), 32'd1);
            chk("idle_alloc_tag",   32'(bus.alloc_tag),   32'd0);
            chk("idle_rf_we",       32'(bus.rf_we),       32'd0);
        end

        // directed table
        for (int i = 0; i < 13; i++) begin
            cycle(vt[i].av, vt[i].fn, vt[i].rd, vt[i].cv, vt[i].ct, vt[i].cd, vt[i].fl, 1'b1);
            chk("vec_count",   32'(bus.count),       32'(vt[i].cnt));
            chk("vec_ready",   32'(bus.alloc_ready), 32'(vt[i].rdy));
            chk("vec_atag",    32'(bus.alloc_tag),   32'(vt[i].atag));
            chk("vec_we",      32'(bus.rf_we),       32'(vt[i].we));
            chk("vec_addr",    32'(bus.rf_addr),     32'(vt[i].addr));
            chk("vec_data",    32'(bus.rf_data),     32'(vt[i].data));
            chk("vec_rtag",    32'(bus.rf_tag),      32'(vt[i].rtag));
            chk("vec_credits", 32'({bus.add_free, bus.mul_free, bus.bch_free}), 32'(vt[i].cred));
            chk("vec_clear",   32'(bus.tags_clear_all), 32'(vt[i].clr));
        end

        // fill to full, reverse-order completion, burst of in-order commits
        for (int i = 0; i < DEPTH; i++) do_alloc(4'(i * 2), 4'(i));
        chk("full_count", 32'(bus.count),       32'd8);
        chk("full_ready", 32'(bus.alloc_ready), 32'd0);
        do_alloc(4'h0, 4'hF);
        chk("full_ignored_count", 32'(bus.count),     32'd8);
        chk("full_ignored_tag",   32'(bus.alloc_tag), 32'd0);
        for (int t = 7; t >= 1; t--) begin
            do_cdb(3'(t), 16'(256 + t));
            chk("ooo_no_commit", 32'(bus.rf_we), 32'd0);
        end
        do_cdb(3'd0, 16'h0100);
        chk("head_cdb_no_commit", 32'(bus.rf_we), 32'd0);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(3'(k));
        for (int k = 0; k < DEPTH; k++) begin
            idle();
            chk("burst_we",   32'(bus.rf_we),   32'd1);
            chk("burst_tag",  32'(bus.rf_tag),  32'(exp_q.pop_front()));
            chk("burst_data", 32'(bus.rf_data), 32'(256 + k));
        end
        idle();
        chk("burst_end_we",    32'(bus.rf_we), 32'd0);
        chk("burst_end_count", 32'(bus.count), 32'd0);

        // wrap-around: 12 alloc/complete/commit rounds
        for (int i = 0; i < 12; i++) begin
            chk("wrap_alloc_tag", 32'(bus.alloc_tag), 32'(i % DEPTH));
            do_alloc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            do_cdb(3'(i % DEPTH), 16'($urandom));
            idle();
            chk("wrap_rf_we",  32'(bus.rf_we),  32'd1);
            chk("wrap_rf_tag", 32'(bus.rf_tag), 32'(i % DEPTH));
            chk("wrap_count_max", 32'(32'(bus.count) <= 32'd8), 32'd1);
        end

        // allocate and commit in the same cycle at count 5
        for (int i = 0; i < 5; i++) begin
            c_tags.push_back(int'(bus.alloc_tag));
            do_alloc(4'(i), 4'(i + 1));
        end
        chk("simul_pre_count", 32'(bus.count), 32'd5);
        do_cdb(3'(c_tags[0]), 16'hC0DE);
        chk("simul_cdb_no_commit", 32'(bus.rf_we), 32'd0);
        t0 = int'(bus.alloc_tag);
        do_alloc(4'h2, 4'hE);
        chk("simul_count",   32'(bus.count),     32'd5);
        chk("simul_tail",    32'(bus.alloc_tag), 32'((t0 + 1) % DEPTH));
        chk("simul_we",      32'(bus.rf_we),     32'd1);
        chk("simul_rf_tag",  32'(bus.rf_tag),    32'(c_tags[0]));
        do_cdb(3'(c_tags[1]), 16'h0BAD);
        idle();
        chk("simul_head_adv", 32'(bus.rf_tag), 32'(c_tags[1]));
        do_flush();

        // flush with 4 in flight, two of them complete
        for (int i = 0; i < 4; i++) do_alloc(4'h4, 4'(i + 8));
        do_cdb(3'd2, 16'h2222);
        do_cdb(3'd3, 16'h3333);
        chk("flush_pre_count", 32'(bus.count), 32'd4);
        do_flush();
        chk("flush_clear",   32'(bus.tags_clear_all), 32'd1);
        chk("flush_we",      32'(bus.rf_we),          32'd0);
        chk("flush_count",   32'(bus.count),          32'd0);
        chk("flush_tag",     32'(bus.alloc_tag),      32'd0);
        chk("flush_credits", 32'({bus.add_free, bus.mul_free, bus.bch_free}), 32'd0);
        idle();
        chk("flush_clear_pulse", 32'(bus.tags_clear_all), 32'd0);
        do_alloc(4'h3, 4'h7);
        chk("post_flush_tag", 32'(bus.alloc_tag), 32'd1);

        // synchronous reset in the middle of traffic
        do_alloc(4'h0, 4'h2);
        do_cdb(3'd0, 16'hBEEF);
        idle();
        chk("pre_reset_addr", 32'(bus.rf_addr), 32'h7);
        cycle(1'b1, 4'h1, 4'h4, 1'b1, 3'd1, 16'h5A5A, 1'b0, 1'b0);
        chk("rst_count", 32'(bus.count),          32'd0);
        chk("rst_ready", 32'(bus.alloc_ready),    32'd1);
        chk("rst_tag",   32'(bus.alloc_tag),      32'd0);
        chk("rst_we",    32'(bus.rf_we),          32'd0);
        chk("rst_clear", 32'(bus.tags_clear_all), 32'd0);
        chk("rst_addr",  32'(bus.rf_addr),        32'd0);
        chk("rst_data",  32'(bus.rf_data),        32'd0);
        idle();

        // random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            cycle(1'($urandom_range(0, 9) < 6),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  16'($urandom),
                  1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 199) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder-buffer storage plus in-order retire engine for the Tomasulo core.
- Issue allocates entries at the tail and receives the entry index as its rename tag.
- CDB writebacks mark entries complete with their result.
- This block retires the head entry in program order:
  - writes the result into the register bank,
  - tells the register bank to drop the rename tag,
  - returns a slot credit to the add, mul or branch reservation-station pool.

Parameters:
- DEPTH, 8, number of ROB entries; must be a power of two.
- IDX_W, 3, log2(DEPTH); width of the ROB index / rename tag.
- DATA_W, 16, result and register data width.
- REG_W, 4, architectural register index width.
- FUNC_W, 4, function code width.

Ports:
- clk1  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- alloc_valid  in  1  issue requests an entry this cycle.
- alloc_func  in  FUNC_W  function code of the issued instruction.
- alloc_rd  in  REG_W  destination register.
- alloc_ready  out  1  entry available: count < DEPTH.
- alloc_tag  out  IDX_W  tail index; the tag given to the accepted instruction.
- cdb_valid  in  1  completion broadcast.
- cdb_tag  in  IDX_W  ROB index being completed.
- cdb_data  in  DATA_W  result value.
- flush  in  1  discard all in-flight entries.
- rf_we  out  1  registered commit strobe.
- rf_addr  out  REG_W  committed destination register.
- rf_data  out  DATA_W  committed value.
- rf_tag  out  IDX_W  index of the retired entry; the register bank clears the rename of rf_addr to 4'b1000 only if its current tag equals rf_tag.
- add_free, mul_free, bch_free  out  1 each  one-cycle credit pulses to the reservation-station counters.
- tags_clear_all  out  1  one-cycle pulse after flush; the register bank clears every rename tag.
- count  out  IDX_W+1  occupied entries, 0..DEPTH.

Behaviour:
- Storage per entry: valid, ready, func, rd, data.
- Pointers: head_p and tail_p, IDX_W bits, wrapping modulo DEPTH.
- Occupancy: count register of IDX_W+1 bits.
- Full is count==DEPTH; empty is count==0. Pointer equality alone is never used.
- Reset (rst_n=0 at posedge):
  - head_p=tail_p=0, count=0, all valid/ready=0.
  - Every output = 0, except alloc_ready=1.
  - Reset overrides all other inputs that cycle, including mid-operation.
- Allocate:
  - Accepted when alloc_valid && alloc_ready.
  - The entry at tail_p gets func and rd, with valid=1 and ready=0.
  - tail_p increments.
  - alloc_tag equals tail_p before the increment.
  - alloc_valid while full is ignored; no state change.
- Writeback:
  - cdb_valid sets ready=1 and data=cdb_data at cdb_tag, only if that entry is valid. Otherwise it is ignored.
  - A second writeback to a ready entry overwrites data.
- Commit (at most one per cycle): when head entry valid && ready, next posedge does all of:
  - rf_we=1, rf_addr=rd, rf_data=data, rf_tag=head_p,
  - one credit pulse by func: 0000/0001 -> add_free, 0010/0011 -> mul_free, all other codes -> bch_free,
  - valid=0, head_p+1.
  - Otherwise rf_we and all credit pulses are 0.
  - rf_addr, rf_data and rf_tag hold their last values when rf_we=0.
- Latency: commit decision uses registered ready, so CDB at cycle N gives rf_we at cycle N+2 at the earliest (ready at N+1 edge; the commit decision at the N+2 edge produces the registered rf_we).
- Simultaneous events:
  - Allocate and commit in the same cycle: count unchanged and both pointers advance.
  - When full, alloc_ready=0 even if a commit happens that cycle; there is no same-cycle bypass.
  - A CDB write to the head in the same cycle the head is checked does not commit until the next cycle.
  - Allocating into the slot being freed that cycle is impossible because the ROB is not full.
- Flush:
  - Has priority over allocate, writeback and commit.
  - Next state: head_p=tail_p=0, count=0, all valid=0.
  - tags_clear_all=1 for one cycle; rf_we=0 and all credits=0 that cycle.
  - The reservation-station owner resets its pool counts on tags_clear_all.
- Wrap-around: entry DEPTH-1 followed by entry 0 behaves identically to adjacent entries.

Decomposition:
- Shared tomasulo package holds:
  - function code constants FUNC_ADD0/ADD1=0000/0001, FUNC_MUL0/MUL1=0010/0011,
  - NO_TAG=4'b1000,
  - ROB_DEPTH and ROB_IDX_W,
  - the rob_entry record type (valid, ready, func, rd, data).
- One sub-module, rob_unit_class: a combinational func -> {add, mul, bch} one-hot decoder. It is reused by issue for its own pool-count increments.

Test Plan:
- Reset then idle -> count=0, alloc_ready=1, alloc_tag=0, rf_we=0 for 5 cycles.
- Allocate add (func 0000, rd=3) then CDB tag 0 data 16'h00AB -> two cycles later rf_we=1, rf_addr=3, rf_data=00AB, rf_tag=0, add_free=1 for exactly one cycle.
- Allocate 8 entries -> alloc_ready=0 and count=8; a 9th alloc_valid is ignored. Complete tags in order 7,6,…,0 -> no commit until tag 0 completes, then 8 commits on consecutive cycles with rf_tag 0..7 in order; mul/bch credits match the funcs.
- Wrap test: 12 alloc/complete/commit cycles -> alloc_tag sequence 0..7,0..3 and rf_tag matches; count never exceeds 8.
- Simultaneous alloc+commit at count=5 -> count stays 5, head_p and tail_p both advance.
- Flush with 4 in-flight entries (2 ready) -> tags_clear_all=1 for one cycle, no rf_we, count=0, next alloc_tag=0. Assert rst_n=0 mid-burst -> same cleared state with tags_clear_all=0.
